// File: rtl/fir_mac_if.sv
// fir_mac_if: sample, coefficient and result bundle between the clock-divider
// side and fir_mac_sequencer.
// The FIR_SAT_EN macro adds the sat_flag result bit.
interface fir_mac_if #(
  parameter int N    = 32,
  parameter int TAPS = 4
);
  logic              sample_en;
  logic [N-1:0]      x_in;
  logic [TAPS*N-1:0] b;
  logic [N-1:0]      y_out;
  logic              y_valid;
  logic              busy;
  logic              overrun;
`ifdef FIR_SAT_EN
  logic              sat_flag;

  modport master (
    output sample_en, x_in, b,
    input  y_out, y_valid, busy, overrun, sat_flag
  );

  modport slave (
    input  sample_en, x_in, b,
    output y_out, y_valid, busy, overrun, sat_flag
  );
`else
  modport master (
    output sample_en, x_in, b,
    input  y_out, y_valid, busy, overrun
  );

  modport slave (
    input  sample_en, x_in, b,
    output y_out, y_valid, busy, overrun
  );
`endif
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR. One shared multiplier and one
// accumulator are stepped over TAPS coefficient/history pairs per accepted
// sample, giving one filtered output per sample.
//
// Optional macro FIR_SAT_EN: products are kept at full 2N width, the
// accumulator grows to 2N+clog2(TAPS) bits and y_out saturates to all-ones
// when the sum does not fit in N bits (sat_flag pulses with y_valid).
// Without the macro all arithmetic wraps modulo 2^N.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for sample_en; strobe writes x_in into hist[head]
// MAC   | one tap per cycle, idx 0..TAPS-1, acc += b[idx]*hist[head-idx]
// DONE  | publish acc on y_out, advance head, back to IDLE
module fir_mac_sequencer #(
  parameter int N    = 32,
  parameter int TAPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  fir_mac_if.slave   bus
);

  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
`ifdef FIR_SAT_EN
  localparam int PW = 2 * N;
  localparam int AW = 2 * N + $clog2(TAPS);
`else
  localparam int PW = N;
  localparam int AW = N;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [N-1:0]  hist [TAPS];
  logic [IW-1:0] head;
  logic [IW-1:0] idx;
  logic [AW-1:0] acc;

  logic [IW-1:0] rd_ptr;
  logic [IW-1:0] head_inc;
  logic [IW-1:0] idx_inc;
  logic          last_tap;
  logic [N-1:0]  coef_sel;
  logic [N-1:0]  hist_sel;
  logic [PW-1:0] prod;
  logic [N-1:0]  y_nxt;

  logic          capture;
  logic          mac_step;
  logic          finish;
  logic          strobe_busy;

  logic [N-1:0]  y_out_q;
  logic          y_valid_q;
  logic          overrun_q;
`ifdef FIR_SAT_EN
  logic          acc_ovf;
  logic          sat_q;
`endif

  // State register; ena low freezes the sequence where it stands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle datapath strobes; a strobe in MAC or DONE is busy.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    mac_step    = 1'b0;
    finish      = 1'b0;
    strobe_busy = 1'b0;
    if (ena) begin
      unique case (state)
        IDLE: begin
          if (bus.sample_en) begin
            capture   = 1'b1;
            state_nxt = MAC;
          end
        end
        MAC: begin
          mac_step    = 1'b1;
          strobe_busy = bus.sample_en;
          if (last_tap) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          finish      = 1'b1;
          strobe_busy = bus.sample_en;
          state_nxt   = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Circular indexing done as explicit modulo TAPS so non-power-of-two
  // tap counts never read a stale slot beyond the buffer.
  always_comb begin
    if (head >= idx) begin
      rd_ptr = head - idx;
    end else begin
      rd_ptr = head + IW'(TAPS) - idx;
    end
    last_tap = (idx == IW'(TAPS - 1));
    idx_inc  = last_tap ? '0 : idx + IW'(1);
    head_inc = (head == IW'(TAPS - 1)) ? '0 : head + IW'(1);
  end

  // Shared multiplier operand select and product.
  always_comb begin
    coef_sel = bus.b[int'(idx) * N +: N];
    hist_sel = hist[rd_ptr];
    prod     = PW'(coef_sel) * PW'(hist_sel);
  end

  // Output value: saturate when the wide sum exceeds N bits, else pass low bits.
`ifdef FIR_SAT_EN
  always_comb begin
    acc_ovf = |acc[AW-1:N];
    y_nxt   = acc_ovf ? {N{1'b1}} : acc[N-1:0];
  end
`else
  always_comb begin
    y_nxt = acc[N-1:0];
  end
`endif

  // History, pointers, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < TAPS; k++) begin
        hist[k] <= '0;
      end
      head      <= '0;
      idx       <= '0;
      acc       <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef FIR_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else if (ena) begin
      y_valid_q <= finish;
`ifdef FIR_SAT_EN
      sat_q     <= finish & acc_ovf;
`endif
      if (strobe_busy) begin
        overrun_q <= 1'b1;
      end
      if (capture) begin
        hist[head] <= bus.x_in;
        acc        <= '0;
        idx        <= '0;
      end
      if (mac_step) begin
        acc <= acc + AW'(prod);
        idx <= idx_inc;
      end
      if (finish) begin
        y_out_q <= y_nxt;
        head    <= head_inc;
      end
    end
  end

  assign bus.y_out    = y_out_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.busy     = (state != IDLE);
  assign bus.overrun  = overrun_q;
`ifdef FIR_SAT_EN
  assign bus.sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: scoreboard bench for fir_mac_sequencer. A TAPS=4
// instance covers impulse, step, enable freeze, overrun and mid-sequence
// reset; a TAPS=1 instance covers the DONE-edge strobe and wrap/saturate.
module tb_fir_mac_sequencer;
  localparam int N    = 32;
  localparam int TAPS = 4;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic ena1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fir_mac_if #(.N(N), .TAPS(TAPS)) bus ();
  fir_mac_if #(.N(N), .TAPS(1))    bus1 ();

  fir_mac_sequencer #(.N(N), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .ena(ena), .bus(bus)
  );

  fir_mac_sequencer #(.N(N), .TAPS(1)) dut1 (
    .clk(clk), .rst(rst), .ena(ena1), .bus(bus1)
  );

  logic [N-1:0] exp_q [$];
  int           exp_cyc_q [$];
  logic [N-1:0] mh [TAPS];
  logic [N-1:0] bc [TAPS];
  int           mhd;
  logic [N-1:0] mon_e;
  int           mon_c;

  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) mh[k] = '0;
    mhd = 0;
  endfunction

  function automatic logic [N-1:0] model_push(input logic [N-1:0] x);
    logic [N-1:0] s;
    s = '0;
    mh[mhd] = x;
    for (int k = 0; k < TAPS; k++) s = s + bc[k] * mh[(mhd - k + TAPS) % TAPS];
    mhd = (mhd + 1) % TAPS;
    return s;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && bus.y_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid y_out=%0d, no output was expected", bus.y_out);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (bus.y_out !== mon_e) begin
          fails++;
          $display("FAIL y_out got=%0d expected=%0d", bus.y_out, mon_e);
        end
        tests++;
        if (cyc !== mon_c) begin
          fails++;
          $display("FAIL latency y_valid at cycle=%0d expected cycle=%0d", cyc, mon_c);
        end
`ifdef FIR_SAT_EN
        tests++;
        if (bus.sat_flag !== 1'b0) begin
          fails++;
          $display("FAIL sat_flag_main got=%b expected=0", bus.sat_flag);
        end
`endif
      end
    end
  end

  task automatic strobe(input logic [N-1:0] x, input int extra,
                        input logic use_c, input logic [N-1:0] c);
    logic [N-1:0] m;
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.x_in      = x;
    m = model_push(x);
    exp_q.push_back(use_c ? c : m);
    exp_cyc_q.push_back(cyc + TAPS + 2 + extra);
    @(negedge clk);
    bus.sample_en = 1'b0;
    bus.x_in      = $urandom();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
    end
  endtask

  task automatic test_reset();
    int nv;
    rst = 1'b0;
    repeat (3) begin
      ena            = 1'($urandom());
      ena1           = 1'($urandom());
      bus.sample_en  = 1'($urandom());
      bus.x_in       = $urandom();
      bus.b          = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus1.sample_en = 1'($urandom());
      bus1.x_in      = $urandom();
      bus1.b         = $urandom();
      @(negedge clk);
    end
    tests++;
    if (bus.y_out !== '0) begin fails++; $display("FAIL reset_y_out got=%0d expected=0", bus.y_out); end
    tests++;
    if (bus.y_valid !== 1'b0) begin fails++; $display("FAIL reset_y_valid got=%b expected=0", bus.y_valid); end
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b expected=0", bus.busy); end
    tests++;
    if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b expected=0", bus.overrun); end
    tests++;
    if (bus1.busy !== 1'b0 || bus1.y_out !== '0) begin
      fails++;
      $display("FAIL reset_taps1 busy=%b y_out=%0d expected 0/0", bus1.busy, bus1.y_out);
    end
    bus.sample_en  = 1'b0;
    bus1.sample_en = 1'b0;
    ena            = 1'b1;
    ena1           = 1'b1;
    bus.b          = {32'd1, 32'd2, 32'd3, 32'd4};
    bus1.b         = 32'd2;
    rst            = 1'b1;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.y_valid === 1'b1 || bus1.y_valid === 1'b1) nv++;
    end
    tests++;
    if (nv !== 0) begin fails++; $display("FAIL reset_idle_valid got=%0d pulses expected=0", nv); end
  endtask

  task automatic test_impulse();
    logic [N-1:0] xs [6];
    logic [N-1:0] ys [6];
    xs = '{32'd0, 32'd101, 32'd0, 32'd0, 32'd0, 32'd0};
    ys = '{32'd0, 32'd404, 32'd303, 32'd202, 32'd101, 32'd0};
    for (int i = 0; i < 6; i++) begin
      strobe(xs[i], 0, 1'b1, ys[i]);
      repeat (248) @(negedge clk);
    end
    wait_drain(50);
  endtask

  task automatic test_step();
    logic [N-1:0] ys [6];
    ys = '{32'd4, 32'd7, 32'd9, 32'd10, 32'd10, 32'd10};
    for (int i = 0; i < 6; i++) begin
      strobe(32'd1, 0, 1'b1, ys[i]);
      repeat (TAPS) @(negedge clk);
    end
    wait_drain(50);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_enable();
    int bad;
    strobe(32'd9, 5, 1'b1, 32'd42);
    ena = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy !== 1'b1 || bus.y_valid !== 1'b0) bad++;
    end
    ena = 1'b1;
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL enable_freeze got=%0d bad cycles expected=0", bad); end
    wait_drain(50);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overrun();
    tests++;
    if (bus.overrun !== 1'b0) begin fails++; $display("FAIL overrun_pre got=%b expected=0", bus.overrun); end
    strobe(32'd20, 0, 1'b0, '0);
    repeat (2) @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL overrun_busy got=%b expected=1", bus.busy); end
    bus.sample_en = 1'b1;
    bus.x_in      = 32'd55;
    @(negedge clk);
    bus.sample_en = 1'b0;
    tests++;
    if (bus.overrun !== 1'b1) begin fails++; $display("FAIL overrun_set got=%b expected=1", bus.overrun); end
    wait_drain(50);
    repeat (4) @(negedge clk);
    strobe(32'd30, 0, 1'b0, '0);
    wait_drain(50);
    tests++;
    if (bus.overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky got=%b expected=1", bus.overrun); end
  endtask

  task automatic test_done_edge();
    tests++;
    if (bus1.overrun !== 1'b0) begin fails++; $display("FAIL done_edge_pre got=%b expected=0", bus1.overrun); end
    @(negedge clk);
    bus1.sample_en = 1'b1;
    bus1.x_in      = 32'd5;
    @(negedge clk);
    bus1.sample_en = 1'b0;
    @(negedge clk);
    bus1.sample_en = 1'b1;
    bus1.x_in      = 32'd77;
    @(negedge clk);
    bus1.sample_en = 1'b0;
    tests++;
    if (bus1.y_valid !== 1'b1 || bus1.y_out !== 32'd10) begin
      fails++;
      $display("FAIL done_edge_out got valid=%b y=%0d expected valid=1 y=10", bus1.y_valid, bus1.y_out);
    end
    tests++;
    if (bus1.overrun !== 1'b1) begin fails++; $display("FAIL done_edge_overrun got=%b expected=1", bus1.overrun); end
`ifdef FIR_SAT_EN
    tests++;
    if (bus1.sat_flag !== 1'b0) begin fails++; $display("FAIL done_edge_sat got=%b expected=0", bus1.sat_flag); end
`endif
    @(negedge clk);
    tests++;
    if (bus1.busy !== 1'b0 || bus1.y_valid !== 1'b0) begin
      fails++;
      $display("FAIL done_edge_ignored got busy=%b valid=%b expected 0/0", bus1.busy, bus1.y_valid);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [N-1:0] ew;
`ifdef FIR_SAT_EN
    ew = 32'hFFFF_FFFF;
`else
    ew = 32'hFFFF_FFFE;
`endif
    @(negedge clk);
    bus1.sample_en = 1'b1;
    bus1.x_in      = 32'hFFFF_FFFF;
    @(negedge clk);
    bus1.sample_en = 1'b0;
    n = 0;
    while (bus1.y_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n !== 2) begin fails++; $display("FAIL wrap_latency got=%0d expected=2", n); end
    tests++;
    if (bus1.y_out !== ew) begin fails++; $display("FAIL wrap_y_out got=%h expected=%h", bus1.y_out, ew); end
`ifdef FIR_SAT_EN
    tests++;
    if (bus1.sat_flag !== 1'b1) begin fails++; $display("FAIL wrap_sat_flag got=%b expected=1", bus1.sat_flag); end
`endif
  endtask

  task automatic test_reset_mid();
    strobe(32'd13, 0, 1'b0, '0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (bus.y_out !== '0 || bus.y_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs got y=%0d v=%b busy=%b ovr=%b expected all 0",
               bus.y_out, bus.y_valid, bus.busy, bus.overrun);
    end
    tests++;
    if (bus1.overrun !== 1'b0 || bus1.y_out !== '0) begin
      fails++;
      $display("FAIL reset_mid_taps1 got ovr=%b y=%0d expected 0/0", bus1.overrun, bus1.y_out);
    end
    exp_q.delete();
    exp_cyc_q.delete();
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    strobe(32'd7, 0, 1'b1, 32'd28);
    wait_drain(50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bc[0] = 32'd4;
    bc[1] = 32'd3;
    bc[2] = 32'd2;
    bc[3] = 32'd1;
    model_clear();
    bus.sample_en  = 1'b0;
    bus.x_in       = '0;
    bus1.sample_en = 1'b0;
    bus1.x_in      = '0;
    test_reset();
    test_impulse();
    test_step();
    test_enable();
    test_overrun();
    test_done_edge();
    test_wrap();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Time-multiplexed FIR controller: one shared N×N multiplier and accumulator, sequenced over TAPS coefficient/history pairs per input sample.
- Replaces the parallel per-tap FIR chain where area matters.
- Sits behind the clock divider. Consumes its one-cycle sample strobe and produces one filtered output per accepted sample.

Parameters:
- N, 32, sample/coefficient/output width in bits.
- TAPS, 4, number of filter taps, ≥1. Non-power-of-two is legal.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ena  input  1  global enable; low freezes all state.
- sample_en  input  1  one-clk sample strobe from clock divider.
- x_in  input  N  new sample, valid when sample_en=1.
- b  input  TAPS*N  coefficients; slice k (bits k*N +: N) multiplies x[n-k]; must be stable while busy=1.
- y_out  output  N  filtered output, held between updates.
- y_valid  output  1  one-cycle pulse when y_out updates.
- busy  output  1  high while a sample is being processed.
- overrun  output  1  sticky flag: strobe arrived while busy.

Behaviour:
- Reset (rst=0, async):
  - State=IDLE.
  - History buffer (TAPS×N) zeroed; head pointer=0; accumulator=0.
  - y_out=0, y_valid=0, busy=0, overrun=0.
  - Reset asserted mid-sequence aborts the sample; no y_valid is produced for it.
- FSM states: IDLE, MAC, DONE. All transitions require ena=1; with ena=0 every register holds, including pointers and the MAC index.
- IDLE:
  - On sample_en=1: write x_in into hist[head], clear acc, idx=0, go to MAC, busy=1.
  - The same edge also samples x_in for tap 0.
- MAC (exactly TAPS cycles, idx 0..TAPS-1):
  - acc <= acc + b[idx] * hist[(head - idx) mod TAPS].
  - Go to DONE after idx=TAPS-1.
  - Index wrap is explicit modulo TAPS, not bit truncation.
- DONE (one cycle):
  - y_out <= acc; y_valid=1 for exactly this following cycle.
  - head <= (head+1) mod TAPS; busy=0; return to IDLE.
- Latency: capture edge E0 → y_out/y_valid registered at edge E(TAPS+1).
- Minimum strobe spacing: TAPS+2 clocks.
- Arithmetic: unsigned. Product truncated to low N bits. Accumulate modulo 2^N, wrap, no flags.
- sample_en while busy=1 (MAC or DONE): strobe ignored, x_in not captured, overrun<=1. overrun is sticky until reset.
- sample_en while ena=0: ignored, no overrun.
- sample_en on the same edge DONE returns to IDLE: counts as busy, so it is ignored and sets overrun.
- TAPS=1: MAC lasts one cycle; head stays 0.

Optional Feature:
- Macro FIR_SAT_EN.
- Defined:
  - Each product is computed full 2N bits, and accumulation is done at 2N+clog2(TAPS) bits.
  - In DONE, y_out saturates to {N{1'b1}} if the accumulated value ≥ 2^N.
  - Adds output sat_flag (1 bit): pulses with y_valid when saturation occurred; reset 0.
- Undefined: wrap arithmetic as above; sat_flag port absent.

Test Plan:
- Reset: hold rst=0 with random inputs → y_out=0, y_valid=0, busy=0, overrun=0. Release; idle 10 clks → no y_valid.
- Impulse: TAPS=4, b slices k0..k3 = 4,3,2,1, strobes every 250 clks, x_in=0,101,0,0,0,0 → y_out sequence 0,404,303,202,101,0. Each y_valid exactly TAPS+1 clks after its strobe.
- Step: same b, x_in=1 on every strobe → y_out 4,7,9,10,10,10.
- Overrun: strobe, then second strobe 3 clks later with x_in=55 → second ignored, overrun=1 and stays 1. Next output is unaffected by 55.
- Enable/reset mid-op: drop ena for 5 clks during MAC → busy and idx hold, result correct, y_valid delayed by 5 clks. Separately, assert rst during MAC → all outputs 0 immediately, history cleared.
- Wrap vs saturate: TAPS=1, b=2, x_in=32'hFFFF_FFFF → without macro y_out=32'hFFFF_FFFE. With FIR_SAT_EN, y_out=32'hFFFF_FFFF and sat_flag pulses.
